// File: rtl/core_cp_restart_seq_if.sv
// core_cp_restart_seq_if
// Bundles every non-clock, non-reset signal of the core restart sequencer:
//   cmd_*      : restart/stop request handshake (valid/ready) plus payload
//   done*      : completion pulse and the core it belongs to
//   busy       : sequencer is not idle
//   host_*     : host (JTAG/control-plane) side of the shared table port
//   tab_*      : core parameter table side of the shared port
// Modports:
//   slave  : the sequencer itself
//   master : whatever drives the commands and models host/table
interface core_cp_restart_seq_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_op;
  logic [1:0]  cmd_core;
  logic [15:0] cmd_dsid;
  logic        done;
  logic [1:0]  done_core;
  logic        busy;
  logic        host_sel;
  logic [14:0] host_col;
  logic [14:0] host_row;
  logic [63:0] host_wdata;
  logic        host_wen;
  logic [63:0] host_rdata;
  logic        host_rd_valid;
  logic        tab_sel;
  logic [14:0] tab_col;
  logic [14:0] tab_row;
  logic [63:0] tab_wdata;
  logic        tab_wen;
  logic [63:0] tab_rdata;

  modport slave (
    input  cmd_valid, cmd_op, cmd_core, cmd_dsid,
    input  host_sel, host_col, host_row, host_wdata, host_wen,
    input  tab_rdata,
    output cmd_ready, done, done_core, busy,
    output host_rdata, host_rd_valid,
    output tab_sel, tab_col, tab_row, tab_wdata, tab_wen
  );

  modport master (
    output cmd_valid, cmd_op, cmd_core, cmd_dsid,
    output host_sel, host_col, host_row, host_wdata, host_wen,
    output tab_rdata,
    input  cmd_ready, done, done_core, busy,
    input  host_rdata, host_rd_valid,
    input  tab_sel, tab_col, tab_row, tab_wdata, tab_wen
  );
endinterface

// File: rtl/core_cp_restart_seq.sv
// core_cp_restart_seq
// Walks one core through a restart using the core parameter table write
// port: state <- SLEEP, wait HOLD_CYCLES, dsid <- new value, state <- RUNNING,
// then wait RST_WAIT_CYCLES for the table's core reset pulse to finish.
// A stop command only performs the SLEEP write. The table port is shared
// with the host, which always wins; a blocked sequencer write simply retries
// the following cycle.
// Ports:
//   SYS_CLK    : clock
//   DETECT_RST : asynchronous active-high reset
//   bus        : command, completion, host and table signals (slave modport)
// Table layout: column 0 = dsid, column 1 = core state, row = core index.
module core_cp_restart_seq #(
  parameter int unsigned HOLD_CYCLES     = 4,
  parameter int unsigned RST_WAIT_CYCLES = 16,
  parameter int unsigned CNT_W           = 8
) (
  input  logic                 SYS_CLK,
  input  logic                 DETECT_RST,
  core_cp_restart_seq_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR_SLEEP = 3'd1,
    ST_HOLD     = 3'd2,
    ST_WR_DSID  = 3'd3,
    ST_WR_RUN   = 3'd4,
    ST_WAIT_RST = 3'd5,
    ST_DONE     = 3'd6
  } state_t;

  // Counters are loaded with N-1 so that a state lasts exactly N cycles.
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(RST_WAIT_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(32'd1);

  state_t           state_r;
  state_t           state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_s;
  logic             op_r;
  logic [1:0]       core_r;
  logic [15:0]      dsid_r;
  logic             done_r;
  logic [1:0]       done_core_r;
  logic             busy_r;

  logic             cmd_ready_s;
  logic             accept_s;
  logic             host_wr_s;
  logic             wr_state_s;
  logic             owned_s;
  logic [14:0]      seq_col_s;
  logic [14:0]      seq_row_s;
  logic [63:0]      seq_wdata_s;

  assign cmd_ready_s = (state_r == ST_IDLE) & ~DETECT_RST;
  assign accept_s    = bus.cmd_valid & cmd_ready_s;
  assign host_wr_s   = bus.host_sel & bus.host_wen;
  // The sequencer only takes the port when the host is not writing.
  assign owned_s     = wr_state_s & ~host_wr_s;
  assign seq_row_s   = {13'd0, core_r};

  // Table access requested by the current write state.
  always_comb begin
    wr_state_s  = 1'b0;
    seq_col_s   = 15'd0;
    seq_wdata_s = 64'd0;
    case (state_r)
      ST_WR_SLEEP: begin
        wr_state_s  = 1'b1;
        seq_col_s   = 15'd1;
        seq_wdata_s = 64'd0;
      end
      ST_WR_DSID: begin
        wr_state_s  = 1'b1;
        seq_col_s   = 15'd0;
        seq_wdata_s = {48'd0, dsid_r};
      end
      ST_WR_RUN: begin
        wr_state_s  = 1'b1;
        seq_col_s   = 15'd1;
        seq_wdata_s = 64'd1;
      end
      default: begin
        wr_state_s  = 1'b0;
        seq_col_s   = 15'd0;
        seq_wdata_s = 64'd0;
      end
    endcase
  end

  // Next-state and counter logic; write states hold until they own the port.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_s = ST_WR_SLEEP;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WR_SLEEP: begin
        if (!owned_s) begin
          state_s = ST_WR_SLEEP;
        end else if (op_r) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_HOLD;
          cnt_s   = HOLD_LOAD;
        end
      end
      ST_HOLD: begin
        if (cnt_r == CNT_ZERO) begin
          state_s = ST_WR_DSID;
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end
      ST_WR_DSID: begin
        if (owned_s) begin
          state_s = ST_WR_RUN;
        end else begin
          state_s = ST_WR_DSID;
        end
      end
      ST_WR_RUN: begin
        if (owned_s) begin
          state_s = ST_WAIT_RST;
          cnt_s   = WAIT_LOAD;
        end else begin
          state_s = ST_WR_RUN;
        end
      end
      ST_WAIT_RST: begin
        if (cnt_r == CNT_ZERO) begin
          state_s = ST_DONE;
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = CNT_ZERO;
      end
    endcase
  end

  // State register.
  always_ff @(posedge SYS_CLK or posedge DETECT_RST) begin
    if (DETECT_RST) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Delay counter shared by HOLD and WAIT_RST.
  always_ff @(posedge SYS_CLK or posedge DETECT_RST) begin
    if (DETECT_RST) begin
      cnt_r <= CNT_ZERO;
    end else begin
      cnt_r <= cnt_s;
    end
  end

  // Command fields captured on the accepting edge.
  always_ff @(posedge SYS_CLK or posedge DETECT_RST) begin
    if (DETECT_RST) begin
      op_r   <= 1'b0;
      core_r <= 2'd0;
      dsid_r <= 16'd0;
    end else if (accept_s) begin
      op_r   <= bus.cmd_op;
      core_r <= bus.cmd_core;
      dsid_r <= bus.cmd_dsid;
    end else begin
      op_r   <= op_r;
      core_r <= core_r;
      dsid_r <= dsid_r;
    end
  end

  // Status outputs registered from the next state so they line up with state_r.
  always_ff @(posedge SYS_CLK or posedge DETECT_RST) begin
    if (DETECT_RST) begin
      done_r      <= 1'b0;
      done_core_r <= 2'd0;
      busy_r      <= 1'b0;
    end else begin
      done_r      <= (state_s == ST_DONE);
      done_core_r <= (state_s == ST_DONE) ? core_r : 2'd0;
      busy_r      <= (state_s != ST_IDLE);
    end
  end

  // Shared table port: sequencer drives it when owned, host otherwise.
  always_comb begin
    bus.tab_sel   = bus.host_sel;
    bus.tab_col   = bus.host_col;
    bus.tab_row   = bus.host_row;
    bus.tab_wdata = bus.host_wdata;
    bus.tab_wen   = bus.host_wen;
    if (owned_s) begin
      bus.tab_sel   = 1'b1;
      bus.tab_col   = seq_col_s;
      bus.tab_row   = seq_row_s;
      bus.tab_wdata = seq_wdata_s;
      bus.tab_wen   = 1'b1;
    end else begin
      bus.tab_sel   = bus.host_sel;
      bus.tab_col   = bus.host_col;
      bus.tab_row   = bus.host_row;
      bus.tab_wdata = bus.host_wdata;
      bus.tab_wen   = bus.host_wen;
    end
  end

  assign bus.host_rdata    = bus.tab_rdata;
  assign bus.host_rd_valid = ~owned_s;
  assign bus.cmd_ready     = cmd_ready_s;
  assign bus.done          = done_r;
  assign bus.done_core     = done_core_r;
  assign bus.busy          = busy_r;

endmodule
